// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-ported SRAM between fetch and data paths.
// Define ARB_RR_EN for round-robin arbitration; default is data-over-fetch priority.
module mem_bus_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_ack_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [3:0]  dm_sel_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic [31:0] dm_rdata_o,
  output logic        dm_ack_o,
  output logic        ram_ce_o,
  output logic        ram_we_o,
  output logic [3:0]  ram_sel_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  input  logic [31:0] ram_rdata_i,
  output logic        stall_req_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        ram_ce_q;
  logic        ram_we_q;
  logic [3:0]  ram_sel_q;
  logic [31:0] ram_addr_q;
  logic [31:0] ram_wdata_q;
  logic        if_ack_q;
  logic        dm_ack_q;
  logic [31:0] if_data_q;
  logic [31:0] dm_rdata_q;

  logic        if_vld;
  logic        dm_vld;
  logic        gnt_if_d;
  logic        gnt_dm_d;

  // A requester acked this cycle is still holding req; keep it out of arbitration.
  assign if_vld = if_req_i & ~if_ack_q;
  assign dm_vld = dm_req_i & ~dm_ack_q;

`ifdef ARB_RR_EN
  // Last granted requester: 0 = fetch, 1 = data.
  logic last_dm_q;

  // Round-robin: on contention favour whoever was not granted last.
  always_comb begin
    gnt_dm_d = dm_vld & (~if_vld | ~last_dm_q);
    gnt_if_d = if_vld & ~gnt_dm_d;
  end
`else
  // Fixed priority: the MEM-stage access is older, so it wins.
  always_comb begin
    gnt_dm_d = dm_vld;
    gnt_if_d = if_vld & ~dm_vld;
  end
`endif

  // Arbiter FSM; all RAM-side and requester-side outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      ram_ce_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_sel_q   <= 4'd0;
      ram_addr_q  <= 32'd0;
      ram_wdata_q <= 32'd0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_data_q   <= 32'd0;
      dm_rdata_q  <= 32'd0;
`ifdef ARB_RR_EN
      last_dm_q   <= 1'b0;
`endif
    end else begin
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (gnt_dm_d) begin
            state_q     <= BUSY_DM;
            cnt_q       <= CNT_INIT;
            ram_ce_q    <= 1'b1;
            ram_we_q    <= dm_we_i;
            ram_sel_q   <= dm_sel_i;
            ram_addr_q  <= dm_addr_i;
            ram_wdata_q <= dm_wdata_i;
`ifdef ARB_RR_EN
            last_dm_q   <= 1'b1;
`endif
          end else if (gnt_if_d) begin
            state_q     <= BUSY_IF;
            cnt_q       <= CNT_INIT;
            ram_ce_q    <= 1'b1;
            ram_we_q    <= 1'b0;
            ram_sel_q   <= 4'hF;
            ram_addr_q  <= if_addr_i;
            ram_wdata_q <= 32'd0;
`ifdef ARB_RR_EN
            last_dm_q   <= 1'b0;
`endif
          end
        end
        BUSY_IF: begin
          if (cnt_q == 4'd0) begin
            state_q   <= IDLE;
            ram_ce_q  <= 1'b0;
            ram_we_q  <= 1'b0;
            if_data_q <= ram_rdata_i;
            if_ack_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        BUSY_DM: begin
          if (cnt_q == 4'd0) begin
            state_q    <= IDLE;
            ram_ce_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            dm_rdata_q <= ram_rdata_i;
            dm_ack_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q  <= IDLE;
          ram_ce_q <= 1'b0;
          ram_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign ram_ce_o    = ram_ce_q;
  assign ram_we_o    = ram_we_q;
  assign ram_sel_o   = ram_sel_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_wdata_o = ram_wdata_q;
  assign if_ack_o    = if_ack_q;
  assign dm_ack_o    = dm_ack_q;
  assign if_data_o   = if_data_q;
  assign dm_rdata_o  = dm_rdata_q;

  // Stall while any requester is waiting for its acknowledge.
  assign stall_req_o = (if_req_i & ~if_ack_q) | (dm_req_i & ~dm_ack_q);

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Arbitrates one single-ported unified SRAM between the instruction-fetch path (PC/IF stage) and the data-access path (MEM stage) of the five-stage pipeline. Requests are latched at grant. The RAM sees one transaction at a time for a fixed number of cycles. The block returns a one-cycle acknowledge with registered read data, and raises a stall request to the pipeline controller while any requester waits.

## Interface
Parameters:
- `WAIT_CYCLES`, default 1: RAM access cycles per transaction; legal range 1–15.

Ports:
- `clk`, in, 1: sole clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `if_req_i`, in, 1: fetch request; held until `if_ack_o`.
- `if_addr_i`, in, 32: fetch byte address.
- `if_data_o`, out, 32: fetched instruction; valid while `if_ack_o`.
- `if_ack_o`, out, 1: one-cycle fetch completion.
- `dm_req_i`, in, 1: data request; held until `dm_ack_o`.
- `dm_we_i`, in, 1: 1 = write, 0 = read.
- `dm_sel_i`, in, 4: byte enables.
- `dm_addr_i`, in, 32: data byte address.
- `dm_wdata_i`, in, 32: write data.
- `dm_rdata_o`, out, 32: read data; valid while `dm_ack_o`.
- `dm_ack_o`, out, 1: one-cycle data completion.
- `ram_ce_o`, out, 1: RAM chip enable.
- `ram_we_o`, out, 1: RAM write enable.
- `ram_sel_o`, out, 4: RAM byte enables.
- `ram_addr_o`, out, 32: RAM address.
- `ram_wdata_o`, out, 32: RAM write data.
- `ram_rdata_i`, in, 32: RAM read data; valid in the last BUSY cycle.
- `stall_req_o`, out, 1: pipeline stall request.

## Operation
- FSM states:
  - IDLE: evaluate requests.
  - BUSY_IF: fetch owns the RAM.
  - BUSY_DM: data path owns the RAM.
- IDLE behaviour:
  - Arbitrate among unmasked requests.
  - On a grant, latch address, we, sel and wdata into the RAM output registers, load the wait counter with `WAIT_CYCLES-1`, and enter BUSY_x.
- Fetch grants drive `ram_we_o`=0 and `ram_sel_o`=4'hF.
- BUSY_x behaviour:
  - `ram_ce_o`=1 with stable latched outputs.
  - The counter decrements each cycle.
  - When the counter reaches 0, the edge captures `ram_rdata_i` into the matching rdata register, sets that ack for the next cycle, and returns to IDLE.
- Ack cycle:
  - The state is IDLE.
  - The acked requester's `req` is masked from arbitration that cycle; the other requester may be granted.
- Default arbitration: fixed priority, data over fetch.
  - The MEM instruction is older, so this ordering avoids deadlock.
- Requests and inputs are latched at grant:
  - Changes to address or data during BUSY are ignored.
  - A `req` dropped mid-transaction still completes and acks.
- Writes: `dm_rdata_o` takes whatever `ram_rdata_i` shows; requesters ignore it.
- `stall_req_o` = (`if_req_i` & ~`if_ack_o`) | (`dm_req_i` & ~`dm_ack_o`). It is combinational.
- Read-data registers hold their value outside ack cycles.

## Timing
- Reset values (synchronous `rst`): state IDLE, all `ram_*` outputs 0, both acks 0, both rdata registers 0, counter 0, last-grant = IF.
- Reset mid-transaction aborts it:
  - No ack is issued.
  - A write in flight may or may not have landed.
- Latency:
  - A `req` seen in IDLE at cycle k gives `ram_ce_o` high in cycles k+1 … k+`WAIT_CYCLES`, and ack in cycle k+`WAIT_CYCLES`+1.
  - Back-to-back throughput is one transaction per `WAIT_CYCLES`+1 cycles.
- Simultaneous requests in IDLE: one grant per arbitration cycle. The loser keeps stalling and is granted in the winner's ack cycle.
- `ram_ce_o` is 0 in IDLE and in ack cycles.

## Configuration
- `ARB_RR_EN` defined: round-robin arbitration.
  - When both requests are present, grant the requester not granted last.
  - A single request is granted regardless.
  - The last-grant register updates at each grant.
- `ARB_RR_EN` undefined: fixed data-over-fetch priority; the last-grant register is not implemented.

## Test plan
- Single read: `WAIT_CYCLES`=1. RAM word at 0x100 = 0xDEADBEEF; `if_req_i` with address 0x100 at cycle 0.
  - Required: `ram_ce_o` high in cycle 1 only, `if_ack_o` in cycle 2, `if_data_o`=0xDEADBEEF, `stall_req_o` high in cycles 0–1.
- Write then read: `WAIT_CYCLES`=3. `dm_req_i` writes 0x12345678 to address 0x200 with `dm_sel_i`=4'b0011, then a read of 0x200 from initial 0.
  - Required: the write ack arrives at cycle 4 and the read returns 0x00005678.
- Collision, fixed priority: both requests asserted at cycle 0.
  - Required: data acked at cycle 2, fetch granted in cycle 2 and acked at cycle 4.
- Collision under `ARB_RR_EN`: both requests held continuously.
  - Required: acks alternate DM, IF, DM, IF at cycles 2, 4, 6, 8.
- Latching: change `dm_addr_i` from 0x300 to 0x304 during BUSY.
  - Required: `ram_addr_o` stays 0x300.
- Reset mid-transaction: assert `rst` in the second BUSY cycle with `WAIT_CYCLES`=3.
  - Required: next cycle in IDLE, all outputs 0, no ack.
